matrix_scan_ctrl: RTL and testbench

//  Row-scan refresh controller for the 8x8 LED matrix driven by the game FSM.

---
 rtl/matrix_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: row-scan refresh controller for an 8x8 LED matrix with frame buffer, blanking, blink and clear
// Ports: updateClk clock, resetN async active-low reset,
//   writeStrobe/rowIndex/val frame-buffer row write, clearReq zero the buffer, blinkEn whole-frame blink,
//   busy high while clearing, clearDone pulse at end of a requested clear,
//   rowSel one-hot row enable, colData column pattern, frameTick pulse at end of row 7 dwell.
module matrix_scan_ctrl #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 4,
  parameter int BLINK_DIV = 16
) (
  input  logic       updateClk,
  input  logic       resetN,
  input  logic       writeStrobe,
  input  logic [2:0] rowIndex,
  input  logic [7:0] val,
  input  logic       clearReq,
  input  logic       blinkEn,
  output logic       busy,
  output logic       clearDone,
  output logic [7:0] rowSel,
  output logic [7:0] colData,
  output logic       frameTick
);
  localparam int CW = $clog2(SCAN_DIV > BLANK_CYC ? SCAN_DIV : BLANK_CYC) + 1;
  localparam int FW = $clog2(BLINK_DIV) + 1;
  typedef enum logic [1:0] {CLEAR = 2'd0, BLANK = 2'd1, DRIVE = 2'd2} state_t;
  state_t        state;
  logic [7:0]    fb [8];
  logic [2:0]    clr_idx, scan_row;
  logic [CW-1:0] cnt;
  logic [FW-1:0] frame_cnt;
  logic          phase_on, via_req;
  logic          blank_end, drive_end, frame_end;
  assign blank_end = cnt == CW'(BLANK_CYC - 1);
  assign drive_end = cnt == CW'(SCAN_DIV - 1);
  // a clear request wins over the end of the last dwell, so no tick is produced then
  assign frame_end = state == DRIVE && drive_end && scan_row == 3'd7 && !clearReq;
  always_ff @(posedge updateClk or negedge resetN) begin
    if (!resetN) begin
      state     <= CLEAR;
      fb        <= '{default: '0};
      clr_idx   <= '0;
      scan_row  <= '0;
      cnt       <= '0;
      via_req   <= 1'b0;
      busy      <= 1'b1;
      clearDone <= 1'b0;
      rowSel    <= '0;
      colData   <= '0;
      frameTick <= 1'b0;
    end else begin
      clearDone <= 1'b0;
      frameTick <= 1'b0;
      // writes land even alongside a clear request; the clear then erases them
      if (state != CLEAR && writeStrobe) fb[rowIndex] <= val;
      if (state != CLEAR && clearReq) begin
        state   <= CLEAR;
        clr_idx <= '0;
        cnt     <= '0;
        via_req <= 1'b1;
        busy    <= 1'b1;
        rowSel  <= '0;
        colData <= '0;
      end else begin
        case (state)
          CLEAR: begin
            fb[clr_idx] <= '0;
            clr_idx     <= clr_idx + 3'd1;
            if (clr_idx == 3'd7) begin
              state     <= BLANK;
              scan_row  <= '0;
              cnt       <= '0;
              busy      <= 1'b0;
              clearDone <= via_req;
              via_req   <= 1'b0;
            end
          end
          BLANK: begin
            if (blank_end) begin
              state   <= DRIVE;
              cnt     <= '0;
              rowSel  <= 8'(1) << scan_row;
              colData <= phase_on ? fb[scan_row] : 8'd0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DRIVE: begin
            if (drive_end) begin
              state     <= BLANK;
              cnt       <= '0;
              scan_row  <= scan_row + 3'd1;
              rowSel    <= '0;
              colData   <= '0;
              frameTick <= scan_row == 3'd7;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state   <= CLEAR;
            clr_idx <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            rowSel  <= '0;
            colData <= '0;
          end
        endcase
      end
    end
  end
  always_ff @(posedge updateClk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (!blinkEn) begin
      frame_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (frame_end) begin
      frame_cnt <= frame_cnt == FW'(BLINK_DIV - 1) ? '0 : frame_cnt + FW'(1);
      phase_on  <= frame_cnt == FW'(BLINK_DIV - 1) ? !phase_on : phase_on;
    end
  end
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb_matrix_scan_ctrl: table vectors plus per-cycle scoreboard for matrix_scan_ctrl
module tb_matrix_scan_ctrl;
  logic       updateClk = 1'b0;
  logic       resetN = 1'b0;
  logic       writeStrobe = 1'b0;
  logic [2:0] rowIndex = '0;
  logic [7:0] val = '0;
  logic       clearReq = 1'b0;
  logic       blinkEn = 1'b0;
  logic       busy, clearDone, frameTick;
  logic [7:0] rowSel, colData;
  matrix_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(2), .BLINK_DIV(2)) dut (
    .updateClk(updateClk), .resetN(resetN), .writeStrobe(writeStrobe), .rowIndex(rowIndex),
    .val(val), .clearReq(clearReq), .blinkEn(blinkEn), .busy(busy), .clearDone(clearDone),
    .rowSel(rowSel), .colData(colData), .frameTick(frameTick)
  );
  always #5 updateClk = ~updateClk;
  int checks = 0;
  int errors = 0;
  logic blink_v = 1'b0;
  // reference: t counts cycles since the scan (re)started; negative while clearing
  int         m_t;
  logic       m_via, m_ph;
  int         m_fc;
  logic [7:0] m_lat;
  logic [7:0] m_fb [8];
  logic [18:0] sb_q [$];
  typedef struct {
    string      name;
    int         adv;
    logic       wr;
    logic [2:0] idx;
    logic [7:0] v;
    logic       busy;
    logic [7:0] rs;
    logic [7:0] col;
    logic       ft;
  } vec_t;
  vec_t tbl [16];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic model_reset();
    m_t = -8; m_via = 1'b0; m_ph = 1'b1; m_fc = 0; m_lat = '0;
    foreach (m_fb[i]) m_fb[i] = '0;
  endtask
  task automatic model_edge(input logic wr, input logic [2:0] idx, input logic [7:0] v, input logic clr, input logic bl);
    logic cd, ft;
    logic [7:0] rs;
    int pos, row;
    cd = 1'b0; ft = 1'b0;
    if (m_t < 0) begin
      m_t++;
      cd = (m_t == 0) && m_via;
      if (m_t == 0) m_via = 1'b0;
    end else if (clr) begin
      foreach (m_fb[i]) m_fb[i] = '0;
      m_t = -8; m_via = 1'b1;
    end else begin
      m_t++;
      if (m_t % 6 == 2) m_lat = m_ph ? m_fb[(m_t / 6) % 8] : 8'd0;
      if (wr) m_fb[idx] = v;
      ft = (m_t % 48 == 0);
    end
    if (!bl) begin
      m_fc = 0; m_ph = 1'b1;
    end else if (ft) begin
      m_fc++;
      if (m_fc == 2) begin m_fc = 0; m_ph = !m_ph; end
    end
    pos = m_t < 0 ? 0 : m_t % 6;
    row = m_t < 0 ? 0 : (m_t / 6) % 8;
    rs = (m_t >= 0 && pos >= 2) ? 8'(1 << row) : 8'd0;
    sb_q.push_back({m_t < 0, cd, rs, rs != 0 ? m_lat : 8'd0, ft});
  endtask
  task automatic cycle(input logic wr, input logic [2:0] idx, input logic [7:0] v, input logic clr);
    logic [18:0] e;
    writeStrobe = wr; rowIndex = idx; val = v; clearReq = clr; blinkEn = blink_v;
    model_edge(wr, idx, v, clr, blink_v);
    @(posedge updateClk);
    #1;
    writeStrobe = 1'b0; clearReq = 1'b0;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("sb_cycle", 32'({busy, clearDone, rowSel, colData, frameTick}), 32'(e));
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 8'd0, 1'b0);
  endtask
  task automatic run_vec(input int k);
    cycle(tbl[k].wr, tbl[k].idx, tbl[k].v, 1'b0);
    idle(tbl[k].adv - 1);
    chk(tbl[k].name, 32'({busy, rowSel, colData, frameTick}),
        32'({tbl[k].busy, tbl[k].rs, tbl[k].col, tbl[k].ft}));
  endtask
  task automatic wait_row(input logic [7:0] target);
    for (int i = 0; i < 60 && rowSel !== target; i++) idle(1);
    chk("wait_row", 32'(rowSel), 32'(target));
  endtask
  initial begin
    logic [7:0] acc;
    int lim;
    tbl[0]  = '{"clear_wr_drop", 1,  1'b1, 3'd3, 8'hE0, 1'b1, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{"clear_end",     7,  1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[2]  = '{"blank_hold",    1,  1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[3]  = '{"row0_on",       1,  1'b0, 3'd0, 8'h00, 1'b0, 8'h01, 8'h00, 1'b0};
    tbl[4]  = '{"row0_last",     3,  1'b0, 3'd0, 8'h00, 1'b0, 8'h01, 8'h00, 1'b0};
    tbl[5]  = '{"row1_blank",    1,  1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[6]  = '{"row3_empty",    14, 1'b0, 3'd0, 8'h00, 1'b0, 8'h08, 8'h00, 1'b0};
    tbl[7]  = '{"frame_tick",    28, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[8]  = '{"tick_drop",     1,  1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{"wr_row3",       1,  1'b1, 3'd3, 8'hE0, 1'b0, 8'h01, 8'h00, 1'b0};
    tbl[10] = '{"row3_e0",       18, 1'b0, 3'd0, 8'h00, 1'b0, 8'h08, 8'hE0, 1'b0};
    tbl[11] = '{"row3_e0_last",  3,  1'b0, 3'd0, 8'h00, 1'b0, 8'h08, 8'hE0, 1'b0};
    tbl[12] = '{"row0_pre",      27, 1'b0, 3'd0, 8'h00, 1'b0, 8'h01, 8'h00, 1'b0};
    tbl[13] = '{"wr_row0_mid",   1,  1'b1, 3'd0, 8'hFF, 1'b0, 8'h01, 8'h00, 1'b0};
    tbl[14] = '{"row0_hold",     1,  1'b0, 3'd0, 8'h00, 1'b0, 8'h01, 8'h00, 1'b0};
    tbl[15] = '{"row0_ff",       46, 1'b0, 3'd0, 8'h00, 1'b0, 8'h01, 8'hFF, 1'b0};
    model_reset();
    repeat (3) @(posedge updateClk);
    #1;
    chk("reset_state", 32'({busy, clearDone, rowSel, colData, frameTick}), 32'({1'b1, 1'b0, 8'h00, 8'h00, 1'b0}));
    @(negedge updateClk);
    resetN = 1'b1;
    for (int k = 0; k < 16; k++) run_vec(k);
    for (int r = 1; r < 8; r++) cycle(1'b1, 3'(r), 8'hFF, 1'b0);
    lim = 0;
    while (frameTick !== 1'b1 && lim < 60) begin idle(1); lim++; end
    chk("wait_tick", 32'(frameTick), 32'd1);
    blink_v = 1'b1;
    for (int f = 0; f < 6; f++) begin
      acc = '0;
      for (int i = 0; i < 48; i++) begin idle(1); acc |= colData; end
      chk("blink_frame", 32'(acc), (f % 4 < 2) ? 32'hFF : 32'h00);
    end
    blink_v = 1'b0;
    wait_row(8'h01);
    chk("blink_off_latch", 32'(colData), 32'hFF);
    wait_row(8'h20);
    cycle(1'b1, 3'd2, 8'h55, 1'b1);
    chk("clr_enter", 32'({busy, rowSel, colData}), 32'({1'b1, 8'h00, 8'h00}));
    for (int i = 0; i < 7; i++) cycle(1'b0, 3'd0, 8'd0, i == 2);
    chk("clr_still_busy", 32'(busy), 32'd1);
    idle(1);
    chk("clr_done", 32'({busy, clearDone}), 32'({1'b0, 1'b1}));
    idle(1);
    chk("clr_done_pulse", 32'(clearDone), 32'd0);
    wait_row(8'h01);
    acc = '0;
    for (int i = 0; i < 48; i++) begin idle(1); acc |= colData; end
    chk("cleared_frame", 32'(acc), 32'h00);
    wait_row(8'h10);
    #3;
    resetN = 1'b0;
    #1;
    chk("async_reset", 32'({busy, clearDone, rowSel, colData, frameTick}), 32'({1'b1, 1'b0, 8'h00, 8'h00, 1'b0}));
    model_reset();
    repeat (2) @(posedge updateClk);
    @(negedge updateClk);
    resetN = 1'b1;
    for (int k = 0; k < 9; k++) run_vec(k);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
